id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, width of register-file operands and sign-extended immediate.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 id_valid  input  1  decode stage holds a real instruction.
REQ-005 id_AluControl, id_regW, id_MemReg, id_memWritte, id_Branch, id_AluSrcD, id_RegD, id_ShiftD, id_MemReadByte, id_MemWriteByte  input  4/1/1/1/1/2/1/4/4/4  control bundle from the decode control unit.
REQ-006 id_rs, id_rt, id_rd  input  5 each  register specifiers of the decoding instruction.
REQ-007 id_a, id_b, id_imm  input  DATA_W each  register-file read data A, B; sign-extended immediate.
REQ-008 hold  input  1  downstream stall; freezes this stage.
REQ-009 flush  input  1  branch taken downstream; kill the decoding instruction.
REQ-010 ex_* outputs  output  same widths as id_* bundle, plus ex_rs, ex_rt, ex_a, ex_b, ex_imm  registered copy for execute stage.
REQ-011 ex_valid  output  1  execute stage holds a real instruction.
REQ-012 ex_dst  output  5  registered destination: id_rd when id_RegD=1, else id_rt.
REQ-013 stall_if  output  1  combinational; hold PC and IF/ID register this cycle.
REQ-014 stall_cnt  output  16  bubble count (see Configuration).

Function
REQ-015 Latency one cycle: with hold=0, flush=0, no hazard, every ex_* output equals the id_* input sampled at the previous rising edge.
REQ-016 Load-use hazard = ex_valid & ex_MemReg & ex_regW & (ex_dst != 0) & id_valid & (ex_dst == id_rs | (ex_dst == id_rt & id_RegD)).
REQ-017 On hazard with hold=0, flush=0: stall_if=1, and the stage loads a bubble at the next edge.
REQ-018 Bubble: ex_valid=0, ex_regW=0, ex_MemReg=0, ex_memWritte=0, ex_Branch=0, ex_AluControl=0000, ex_AluSrcD=00, ex_RegD=0, ex_ShiftD=0, ex_MemReadByte=1111, ex_MemWriteByte=1111, ex_dst=0; data fields zero.
REQ-019 Hazard lasts exactly one cycle per load: after the bubble, ex_MemReg=0 so stall_if deasserts.
REQ-020 flush=1 (hold=0): bubble loaded at next edge, stall_if=0 regardless of hazard; flush has priority over hazard.
REQ-021 hold=1: all ex_* registers and ex_valid keep their values, stall_if=1; hold has priority over flush and hazard.
REQ-022 id_valid=0 with no hold: bubble loaded.
REQ-023 Registers with specifier 0 never create a hazard.

Reset
REQ-024 reset=1 at a rising edge loads the bubble of REQ-018, clears stall_cnt; reset has priority over hold, flush, hazard.
REQ-025 While reset=1, stall_if=0; first real instruction captured on the first edge after reset deasserts.

Configuration
REQ-026 Macro ID_EX_STALL_CNT_EN defined: stall_cnt increments by 1 each edge where a hazard bubble is inserted (REQ-017), saturating at 16'hFFFF; flush bubbles not counted.
REQ-027 Macro ID_EX_STALL_CNT_EN undefined: no counter logic; stall_cnt tied to 16'h0000.

Verification
REQ-028 ADD (id_AluControl=0000, id_RegD=1, rd=3) for one cycle -> next cycle ex_valid=1, ex_dst=3, ex_AluControl=0000, stall_if=0.
REQ-029 LW rt=5 then ADD rs=5 -> stall_if=1 during ADD decode; next cycle bubble (ex_valid=0, ex_regW=0); following cycle ADD in EX; stall_cnt=1 when enabled.
REQ-030 LW rt=0 then ADD rs=0 -> stall_if never asserts.
REQ-031 Hazard and flush=1 same cycle -> stall_if=0, bubble loaded, stall_cnt unchanged.
REQ-032 hold=1 for 3 cycles with changing id_* -> ex_* frozen, stall_if=1; after release ex_* follows id_* with one-cycle latency.
REQ-033 reset=1 mid-stream with hold=1 -> next edge all outputs bubble values, stall_cnt=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection, flush and hold
// Optional bubble counter enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [3:0]        id_AluControl,
    input  logic              id_regW,
    input  logic              id_MemReg,
    input  logic              id_memWritte,
    input  logic              id_Branch,
    input  logic [1:0]        id_AluSrcD,
    input  logic              id_RegD,
    input  logic [3:0]        id_ShiftD,
    input  logic [3:0]        id_MemReadByte,
    input  logic [3:0]        id_MemWriteByte,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [DATA_W-1:0] id_a,
    input  logic [DATA_W-1:0] id_b,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              hold,
    input  logic              flush,
    output logic              ex_valid,
    output logic [3:0]        ex_AluControl,
    output logic              ex_regW,
    output logic              ex_MemReg,
    output logic              ex_memWritte,
    output logic              ex_Branch,
    output logic [1:0]        ex_AluSrcD,
    output logic              ex_RegD,
    output logic [3:0]        ex_ShiftD,
    output logic [3:0]        ex_MemReadByte,
    output logic [3:0]        ex_MemWriteByte,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_dst,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic              stall_if,
    output logic [15:0]       stall_cnt
);

    logic hazard;
    logic load_bubble;

    // A load in EX whose destination is read by the decoding instruction; rt only counts for R-type.
    assign hazard = ex_valid && ex_MemReg && ex_regW && (ex_dst != 5'd0) && id_valid &&
                    ((ex_dst == id_rs) || ((ex_dst == id_rt) && id_RegD));

    always_comb begin
        stall_if = 1'b0;
        if (reset)
            stall_if = 1'b0;
        else if (hold)
            stall_if = 1'b1;
        else if (flush)
            stall_if = 1'b0;
        else
            stall_if = hazard;
    end

    assign load_bubble = reset || (!hold && (flush || hazard || !id_valid));

    always_ff @(posedge clk) begin
        if (load_bubble) begin
            ex_valid        <= 1'b0;
            ex_AluControl   <= 4'b0000;
            ex_regW         <= 1'b0;
            ex_MemReg       <= 1'b0;
            ex_memWritte    <= 1'b0;
            ex_Branch       <= 1'b0;
            ex_AluSrcD      <= 2'b00;
            ex_RegD         <= 1'b0;
            ex_ShiftD       <= 4'b0000;
            ex_MemReadByte  <= 4'b1111;
            ex_MemWriteByte <= 4'b1111;
            ex_rs           <= 5'd0;
            ex_rt           <= 5'd0;
            ex_dst          <= 5'd0;
            ex_a            <= '0;
            ex_b            <= '0;
            ex_imm          <= '0;
        end else if (!hold) begin
            ex_valid        <= 1'b1;
            ex_AluControl   <= id_AluControl;
            ex_regW         <= id_regW;
            ex_MemReg       <= id_MemReg;
            ex_memWritte    <= id_memWritte;
            ex_Branch       <= id_Branch;
            ex_AluSrcD      <= id_AluSrcD;
            ex_RegD         <= id_RegD;
            ex_ShiftD       <= id_ShiftD;
            ex_MemReadByte  <= id_MemReadByte;
            ex_MemWriteByte <= id_MemWriteByte;
            ex_rs           <= id_rs;
            ex_rt           <= id_rt;
            ex_dst          <= id_RegD ? id_rd : id_rt;
            ex_a            <= id_a;
            ex_b            <= id_b;
            ex_imm          <= id_imm;
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    logic [15:0] cnt_q;

    // Only hazard bubbles are counted; a flush in the same cycle wins and is not a stall.
    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= 16'h0000;
        else if (!hold && !flush && hazard && (cnt_q != 16'hFFFF))
            cnt_q <= cnt_q + 16'h0001;
    end

    assign stall_cnt = cnt_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard testbench for id_ex_stage
module tb_id_ex_stage;

    typedef struct packed {
        logic        rst;
        logic        hold;
        logic        flush;
        logic        valid;
        logic [3:0]  alu;
        logic        regw;
        logic        memreg;
        logic        memw;
        logic        branch;
        logic [1:0]  alusrc;
        logic        regd;
        logic [3:0]  shift;
        logic [3:0]  mrb;
        logic [3:0]  mwb;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
    } stim_t;

    typedef struct packed {
        logic [23:0] ctrl;
        logic [14:0] regs;
        logic [95:0] data;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset, id_valid, id_regW, id_MemReg, id_memWritte, id_Branch, id_RegD, hold, flush;
    logic [3:0] id_AluControl, id_ShiftD, id_MemReadByte, id_MemWriteByte;
    logic [1:0] id_AluSrcD;
    logic [4:0] id_rs, id_rt, id_rd;
    logic [31:0] id_a, id_b, id_imm;
    logic ex_valid, ex_regW, ex_MemReg, ex_memWritte, ex_Branch, ex_RegD, stall_if;
    logic [3:0] ex_AluControl, ex_ShiftD, ex_MemReadByte, ex_MemWriteByte;
    logic [1:0] ex_AluSrcD;
    logic [4:0] ex_rs, ex_rt, ex_dst;
    logic [31:0] ex_a, ex_b, ex_imm;
    logic [15:0] stall_cnt;

    id_ex_stage #(.DATA_W(32)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_AluControl(id_AluControl), .id_regW(id_regW), .id_MemReg(id_MemReg),
        .id_memWritte(id_memWritte), .id_Branch(id_Branch), .id_AluSrcD(id_AluSrcD),
        .id_RegD(id_RegD), .id_ShiftD(id_ShiftD), .id_MemReadByte(id_MemReadByte),
        .id_MemWriteByte(id_MemWriteByte), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_a(id_a), .id_b(id_b), .id_imm(id_imm), .hold(hold), .flush(flush),
        .ex_valid(ex_valid), .ex_AluControl(ex_AluControl), .ex_regW(ex_regW),
        .ex_MemReg(ex_MemReg), .ex_memWritte(ex_memWritte), .ex_Branch(ex_Branch),
        .ex_AluSrcD(ex_AluSrcD), .ex_RegD(ex_RegD), .ex_ShiftD(ex_ShiftD),
        .ex_MemReadByte(ex_MemReadByte), .ex_MemWriteByte(ex_MemWriteByte),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst), .ex_a(ex_a), .ex_b(ex_b),
        .ex_imm(ex_imm), .stall_if(stall_if), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    exp_t sb_q[$];

    // Reference state of the EX register, kept independently of the DUT.
    logic        m_valid, m_regw, m_memreg;
    logic [4:0]  m_dst;
    logic [15:0] m_cnt;
    exp_t        m_exp;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    function automatic exp_t bubble_exp(input logic [15:0] cnt);
        exp_t e;
        e.ctrl = {1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'b0000, 4'b1111, 4'b1111};
        e.regs = 15'd0;
        e.data = 96'd0;
        e.cnt  = cnt;
        return e;
    endfunction

    task automatic step(input stim_t s, input string tag);
        logic hz, exp_stall;
        exp_t e;
        @(negedge clk);
        reset = s.rst; hold = s.hold; flush = s.flush; id_valid = s.valid;
        id_AluControl = s.alu; id_regW = s.regw; id_MemReg = s.memreg; id_memWritte = s.memw;
        id_Branch = s.branch; id_AluSrcD = s.alusrc; id_RegD = s.regd; id_ShiftD = s.shift;
        id_MemReadByte = s.mrb; id_MemWriteByte = s.mwb; id_rs = s.rs; id_rt = s.rt; id_rd = s.rd;
        id_a = s.a; id_b = s.b; id_imm = s.imm;
        #1;
        hz = m_valid && m_memreg && m_regw && (m_dst != 0) && s.valid &&
             ((m_dst == s.rs) || ((m_dst == s.rt) && s.regd));
        exp_stall = s.rst ? 1'b0 : s.hold ? 1'b1 : s.flush ? 1'b0 : hz;
        check({tag, ".stall_if"}, {127'd0, stall_if}, {127'd0, exp_stall});
        if (s.rst) begin
            m_cnt = 16'd0;
            e = bubble_exp(16'd0);
            m_valid = 0; m_regw = 0; m_memreg = 0; m_dst = 0;
        end else if (s.hold) begin
            e = m_exp;
        end else if (s.flush || hz || !s.valid) begin
`ifdef ID_EX_STALL_CNT_EN
            if (hz && !s.flush && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
`endif
            e = bubble_exp(m_cnt);
            m_valid = 0; m_regw = 0; m_memreg = 0; m_dst = 0;
        end else begin
            m_valid = 1; m_regw = s.regw; m_memreg = s.memreg;
            m_dst = s.regd ? s.rd : s.rt;
            e.ctrl = {1'b1, s.alu, s.regw, s.memreg, s.memw, s.branch, s.alusrc, s.regd,
                      s.shift, s.mrb, s.mwb};
            e.regs = {s.rs, s.rt, m_dst};
            e.data = {s.a, s.b, s.imm};
            e.cnt  = m_cnt;
        end
        m_exp = e;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 128'd1, 128'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, ".ctrl"}, {104'd0, ex_valid, ex_AluControl, ex_regW, ex_MemReg,
                  ex_memWritte, ex_Branch, ex_AluSrcD, ex_RegD, ex_ShiftD, ex_MemReadByte,
                  ex_MemWriteByte}, {104'd0, e.ctrl});
            check({tag, ".regs"}, {113'd0, ex_rs, ex_rt, ex_dst}, {113'd0, e.regs});
            check({tag, ".data"}, {32'd0, ex_a, ex_b, ex_imm}, {32'd0, e.data});
            check({tag, ".cnt"}, {112'd0, stall_cnt}, {112'd0, e.cnt});
        end
    endtask

    function automatic stim_t instr(input logic [3:0] alu, input logic regw, input logic memreg,
                                    input logic regd, input logic [4:0] rs, input logic [4:0] rt,
                                    input logic [4:0] rd);
        stim_t s;
        s = '0;
        s.valid = 1; s.alu = alu; s.regw = regw; s.memreg = memreg; s.regd = regd;
        s.alusrc = regd ? 2'b00 : 2'b01; s.mrb = 4'b0011; s.mwb = 4'b0101; s.shift = 4'd2;
        s.rs = rs; s.rt = rt; s.rd = rd;
        s.a = $urandom; s.b = $urandom; s.imm = $urandom;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s = stim_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
        s.rst = 0;
        s.hold = ($urandom_range(0, 5) == 0);
        s.flush = ($urandom_range(0, 6) == 0);
        s.valid = ($urandom_range(0, 7) != 0);
        s.rs = 5'($urandom_range(0, 3)); s.rt = 5'($urandom_range(0, 3));
        s.rd = 5'($urandom_range(0, 3));
        s.regw = ($urandom_range(0, 3) != 0);
        s.memreg = ($urandom_range(0, 1) != 0);
        return s;
    endfunction

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_LW  = 4'b0010;

    initial begin
        stim_t s, lw, add;
        m_valid = 0; m_regw = 0; m_memreg = 0; m_dst = 0; m_cnt = 0;
        m_exp = bubble_exp(16'd0);
        reset = 1; hold = 0; flush = 0; id_valid = 0;
        id_AluControl = 0; id_regW = 0; id_MemReg = 0; id_memWritte = 0; id_Branch = 0;
        id_AluSrcD = 0; id_RegD = 0; id_ShiftD = 0; id_MemReadByte = 0; id_MemWriteByte = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_a = 0; id_b = 0; id_imm = 0;

        s = instr(ALU_ADD, 1, 0, 1, 1, 2, 3); s.rst = 1; s.hold = 1;
        step(s, "reset_hold");
        s.hold = 0;
        step(s, "reset");

        add = instr(ALU_ADD, 1, 0, 1, 1, 2, 3);
        step(add, "add");

        lw = instr(ALU_LW, 1, 1, 0, 1, 5, 0);
        step(lw, "lw_rt5");
        add = instr(ALU_ADD, 1, 0, 1, 5, 2, 7);
        step(add, "add_stall");
        step(add, "add_after_bubble");
        step(instr(ALU_ADD, 1, 0, 1, 1, 2, 8), "add_in_ex");

        step(instr(ALU_LW, 1, 1, 0, 2, 0, 0), "lw_rt0");
        step(instr(ALU_ADD, 1, 0, 1, 0, 0, 4), "add_rs0");

        step(instr(ALU_LW, 1, 1, 0, 1, 6, 0), "lw_rt6");
        s = instr(ALU_ADD, 1, 0, 1, 6, 2, 9); s.flush = 1;
        step(s, "hazard_flush");

        step(instr(ALU_ADD, 1, 0, 1, 3, 4, 10), "pre_hold");
        for (int i = 0; i < 3; i++) begin
            s = instr(4'(i + 5), 1, 0, 1, 5'(i), 5'(i + 1), 5'(i + 2));
            s.hold = 1; s.flush = (i == 1);
            step(s, "hold");
        end
        step(instr(ALU_ADD, 1, 0, 1, 11, 12, 13), "after_hold");

        step(instr(ALU_LW, 1, 1, 1, 1, 2, 14), "lw_rd14");
        step(instr(ALU_ADD, 1, 0, 0, 2, 14, 1), "itype_rt14");
        step(instr(ALU_ADD, 1, 0, 1, 14, 3, 1), "add_rs14");
        s = '0;
        step(s, "invalid");

        for (int i = 0; i < 40; i++) step(rand_stim(), "rand");

        step(instr(ALU_LW, 1, 1, 0, 1, 5, 0), "lw_pre_rst");
        s = instr(ALU_ADD, 1, 0, 1, 5, 2, 7); s.rst = 1; s.hold = 1;
        step(s, "rst_mid_hold");
        step(instr(ALU_ADD, 1, 0, 1, 1, 2, 3), "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
